// File: rtl/burst_req_issuer_pkg.sv
// Package adapter_issue_pkg: shared types and constants for burst_req_issuer.
//   state_t          issuer FSM states
//   BEAT_SHIFT       log2 of the default bytes-per-beat
//   PAGE_BYTES       4 KB page size used by the optional boundary limit
//   PAGE_LIMIT_EN    1 when BURST_BOUNDARY_4K_EN is defined
//   beat_shift()     log2 helper for a parameterised beat size
// Configuration macro: BURST_BOUNDARY_4K_EN
package adapter_issue_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN
  } state_t;

  localparam int unsigned DEF_BYTES_PER_BEAT = 8;
  localparam int unsigned BEAT_SHIFT         = $clog2(DEF_BYTES_PER_BEAT);
  localparam int unsigned PAGE_BYTES         = 4096;

`ifdef BURST_BOUNDARY_4K_EN
  localparam bit PAGE_LIMIT_EN = 1'b1;
`else
  localparam bit PAGE_LIMIT_EN = 1'b0;
`endif

  function automatic int unsigned beat_shift(input int unsigned bytes_per_beat);
    return $clog2(bytes_per_beat);
  endfunction

endpackage

// File: rtl/burst_req_issuer_if.sv
// Interface burst_req_issuer_if: command, request, response and tracker
// signals of the burst issuer.
//   master modport : issuer side (accepts commands, issues requests,
//                    drives tracker pulses)
//   slave modport  : environment side (command source, downstream,
//                    responder and outstanding-burst tracker)
interface burst_req_issuer_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned LEN_WIDTH  = 16
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [LEN_WIDTH-1:0]  cmd_beats;
  logic                  req_valid;
  logic                  req_ready;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [7:0]            req_len;
  logic                  rsp_valid;
  logic                  rsp_last;
  logic                  trk_up;
  logic                  trk_down;
  logic                  trk_full;
  logic                  trk_empty;

  modport master (
    input  cmd_valid, cmd_addr, cmd_beats, req_ready, rsp_valid, rsp_last,
           trk_full, trk_empty,
    output cmd_ready, req_valid, req_addr, req_len, trk_up, trk_down
  );

  modport slave (
    output cmd_valid, cmd_addr, cmd_beats, req_ready, rsp_valid, rsp_last,
           trk_full, trk_empty,
    input  cmd_ready, req_valid, req_addr, req_len, trk_up, trk_down
  );
endinterface

// File: rtl/burst_req_issuer_len_calc.sv
// Module burst_len_calc: combinational burst length for the next request.
//   remaining  in   beats still to issue
//   page_off   in   low 12 bits of the current burst address
//   len        out  beats in this burst = min(remaining, BURST_MAX [, 4K room])
//   req_len    out  len - 1 (0 when len is 0)
// Configuration macro: BURST_BOUNDARY_4K_EN (limits len to the room left in
// the current 4 KB page).
module burst_len_calc
  import adapter_issue_pkg::*;
#(
  parameter int unsigned LEN_WIDTH      = 16,
  parameter int unsigned BURST_MAX      = 16,
  parameter int unsigned BYTES_PER_BEAT = DEF_BYTES_PER_BEAT
) (
  input  logic [LEN_WIDTH-1:0] remaining,
  input  logic [11:0]          page_off,
  output logic [LEN_WIDTH-1:0] len,
  output logic [7:0]           req_len
);
  localparam int unsigned SHIFT = beat_shift(BYTES_PER_BEAT);

  logic [31:0] rem_w;
  logic [31:0] lim;
  logic [31:0] page_lim;
  logic [31:0] len_w;

  always_comb begin
    rem_w    = 32'(remaining);
    lim      = 32'(BURST_MAX);
    // Address is beat aligned, so the page room is always at least one beat.
    page_lim = (32'(PAGE_BYTES) - 32'(page_off)) >> SHIFT;
    if (PAGE_LIMIT_EN && (page_lim < lim)) begin
      lim = page_lim;
    end
    len_w   = (rem_w < lim) ? rem_w : lim;
    len     = len_w[LEN_WIDTH-1:0];
    req_len = (len_w == 32'd0) ? 8'd0 : 8'(len_w - 32'd1);
  end
endmodule

// File: rtl/burst_req_issuer.sv
// Module burst_req_issuer: splits a transfer command (start address, beat
// count) into bursts issued on a valid/ready request port, driving the
// up/down pulses of an external outstanding-burst tracker.
//   clk, rst     clock, asynchronous active-high reset (shared with tracker)
//   bus          burst_req_issuer_if.master: cmd_*, req_*, rsp_*, trk_*
//   busy         transfer in progress (ISSUE or DRAIN)
//   done         one-cycle pulse when a transfer completes
//   err_rsp      sticky: rsp_last seen with nothing outstanding
// Configuration macro: BURST_BOUNDARY_4K_EN (no burst crosses a 4 KB page).
module burst_req_issuer
  import adapter_issue_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned LEN_WIDTH      = 16,
  parameter int unsigned BURST_MAX      = 16,
  parameter int unsigned BYTES_PER_BEAT = DEF_BYTES_PER_BEAT
) (
  input  logic                clk,
  input  logic                rst,
  burst_req_issuer_if.master  bus,
  output logic                busy,
  output logic                done,
  output logic                err_rsp
);
  localparam int unsigned SHIFT = beat_shift(BYTES_PER_BEAT);
  localparam logic [ADDR_WIDTH-1:0] LOW_MASK = ADDR_WIDTH'(BYTES_PER_BEAT - 1);

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LEN_WIDTH-1:0]  rem_q, rem_d;
  logic [LEN_WIDTH-1:0]  len;
  logic [7:0]            req_len;
  logic                  pend_q;
  logic                  rdy_en_q;
  logic                  done_q;
  logic                  err_q;
  logic                  cmd_acc;
  logic                  rsp_end;
  logic                  rsp_bad;

  burst_len_calc #(
    .LEN_WIDTH      (LEN_WIDTH),
    .BURST_MAX      (BURST_MAX),
    .BYTES_PER_BEAT (BYTES_PER_BEAT)
  ) u_len_calc (
    .remaining (rem_q),
    .page_off  (addr_q[11:0]),
    .len       (len),
    .req_len   (req_len)
  );

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    rem_d         = rem_q;
    cmd_acc       = 1'b0;
    bus.cmd_ready = 1'b0;
    bus.req_valid = 1'b0;
    bus.trk_up    = 1'b0;
    unique case (state_q)
      IDLE: begin
        // rdy_en_q keeps cmd_ready low until the first edge after reset.
        bus.cmd_ready = rdy_en_q;
        cmd_acc       = bus.cmd_valid & rdy_en_q;
        if (cmd_acc) begin
          addr_d = bus.cmd_addr & ~LOW_MASK;
          rem_d  = bus.cmd_beats;
          if (bus.cmd_beats != '0) begin
            state_d = ISSUE;
          end
        end
      end
      ISSUE: begin
        // A pending request ignores trk_full; addr_q/rem_q only move on a
        // handshake, so address and length stay stable while pending.
        bus.req_valid = pend_q | ~bus.trk_full;
        bus.trk_up    = bus.req_valid & bus.req_ready;
        if (bus.trk_up) begin
          addr_d = addr_q + (ADDR_WIDTH'(len) << SHIFT);
          rem_d  = rem_q - len;
          if (rem_q == len) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (bus.trk_empty) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A burst end with nothing outstanding (and no issue this cycle) would
  // underflow the tracker, so it is dropped and flagged instead.
  assign rsp_end      = bus.rsp_valid & bus.rsp_last;
  assign rsp_bad      = rsp_end & bus.trk_empty & ~bus.trk_up;
  assign bus.trk_down = rsp_end & ~rsp_bad;
  assign bus.req_addr = addr_q;
  assign bus.req_len  = req_len;
  assign busy         = (state_q != IDLE);
  assign done         = done_q | ((state_q == DRAIN) & bus.trk_empty);
  assign err_rsp      = err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      rem_q    <= '0;
      pend_q   <= 1'b0;
      rdy_en_q <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      rem_q    <= rem_d;
      pend_q   <= bus.req_valid & ~bus.req_ready;
      rdy_en_q <= 1'b1;
      done_q   <= cmd_acc & (bus.cmd_beats == '0);
      err_q    <= err_q | rsp_bad;
    end
  end
endmodule

// File: tb/tb_burst_req_issuer.sv
// Self-checking bench for burst_req_issuer with a 4-deep tracker model.
module tb_burst_req_issuer;
  localparam int unsigned AW = 32;
  localparam int unsigned LW = 16;
  localparam int unsigned TRK_LIMIT = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic busy, done, err_rsp;
  always #5 clk = ~clk;

  burst_req_issuer_if #(.ADDR_WIDTH(AW), .LEN_WIDTH(LW)) bus ();

  burst_req_issuer #(
    .ADDR_WIDTH     (AW),
    .LEN_WIDTH      (LW),
    .BURST_MAX      (16),
    .BYTES_PER_BEAT (8)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .busy    (busy),
    .done    (done),
    .err_rsp (err_rsp)
  );

  // Outstanding-burst tracker model
  int unsigned trk_cnt;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) trk_cnt <= 0;
    else if (bus.trk_up && !bus.trk_down) trk_cnt <= trk_cnt + 1;
    else if (!bus.trk_up && bus.trk_down) trk_cnt <= trk_cnt - 1;
  end
  assign bus.trk_full  = (trk_cnt == TRK_LIMIT);
  assign bus.trk_empty = (trk_cnt == 0);

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  typedef struct packed {
    logic [31:0] addr;
    logic [7:0]  len;
  } req_t;

  req_t        exp_q[$];
  int unsigned rsp_q[$];
  int unsigned cyc = 0;
  int unsigned hs_cnt = 0;
  int unsigned rv_cnt = 0;
  int unsigned last_down_cyc = 0;
  bit          auto_rsp = 1'b0;
  bit          inject = 1'b0;

  always @(posedge clk) cyc++;

  // Request monitor / scoreboard
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.req_valid) rv_cnt++;
      if (bus.trk_down) last_down_cyc = cyc;
      if (bus.req_valid && bus.req_ready) begin
        req_t e;
        hs_cnt++;
        chk("trk_up_on_hs", 64'(bus.trk_up), 64'(1));
        if (exp_q.size() == 0) begin
          chk("sb_unexpected_req", 64'(exp_q.size()), 64'(1));
        end else begin
          e = exp_q.pop_front();
          chk("req_addr", 64'(bus.req_addr), 64'(e.addr));
          chk("req_len", 64'(bus.req_len), 64'(e.len));
        end
        if (auto_rsp) rsp_q.push_back(int'(bus.req_len) + 1);
      end else if (bus.trk_up) begin
        chk("trk_up_no_hs", 64'(bus.trk_up), 64'(0));
      end
    end
  end

  // Responder: returns the beats of each queued burst, or one injected rsp_last
  initial begin
    int unsigned beats_left = 0;
    bus.rsp_valid = 1'b0;
    bus.rsp_last  = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (inject) begin
        inject = 1'b0;
        bus.rsp_valid = 1'b1;
        bus.rsp_last  = 1'b1;
      end else if (beats_left == 0 && rsp_q.size() != 0) begin
        beats_left = rsp_q.pop_front();
      end
      if (!bus.rsp_last || !bus.rsp_valid || beats_left != 0) begin
        if (beats_left != 0 && !(bus.rsp_valid && bus.rsp_last && beats_left == 0)) begin
          beats_left--;
          bus.rsp_valid = 1'b1;
          bus.rsp_last  = (beats_left == 0);
        end else if (!(bus.rsp_valid && bus.rsp_last)) begin
          bus.rsp_valid = 1'b0;
          bus.rsp_last  = 1'b0;
        end
      end
      // Any rsp_last (injected or end of burst) lasts exactly one cycle.
      @(negedge clk);
      if (bus.rsp_last) begin
        @(posedge clk);
        #1;
        bus.rsp_valid = 1'b0;
        bus.rsp_last  = 1'b0;
        if (inject) begin
          inject = 1'b0;
          bus.rsp_valid = 1'b1;
          bus.rsp_last  = 1'b1;
        end else if (rsp_q.size() != 0) begin
          beats_left = rsp_q.pop_front() - 1;
          bus.rsp_valid = 1'b1;
          bus.rsp_last  = (beats_left == 0);
        end
        @(negedge clk);
        if (bus.rsp_last) begin
          @(posedge clk);
          #1;
          bus.rsp_valid = 1'b0;
          bus.rsp_last  = 1'b0;
        end
      end
    end
  end

  task automatic send_cmd(input logic [31:0] a, input logic [15:0] b);
    int unsigned n = 0;
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b1;
    bus.cmd_addr  = a;
    bus.cmd_beats = b;
    @(negedge clk);
    while (!bus.cmd_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("cmd_accept", 64'(bus.cmd_ready), 64'(1));
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int unsigned budget, output int unsigned at);
    int unsigned n = 0;
    @(negedge clk);
    while (!done && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("done_seen", 64'(done), 64'(1));
    at = cyc;
  endtask

  task automatic push_exp(input logic [31:0] a, input logic [7:0] l);
    req_t e;
    e.addr = a;
    e.len  = l;
    exp_q.push_back(e);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned at;
    int unsigned hs0;
    int unsigned rv0;
    bus.cmd_valid = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_beats = '0;
    bus.req_ready = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_cmd_ready", 64'(bus.cmd_ready), 64'(0));
    chk("rst_req_valid", 64'(bus.req_valid), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_err", 64'(err_rsp), 64'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("cmd_ready_after_rst", 64'(bus.cmd_ready), 64'(1));

    // 1: 40 beats from 0x1000
    auto_rsp = 1'b1;
    bus.req_ready = 1'b1;
    push_exp(32'h1000, 8'd15);
    push_exp(32'h1080, 8'd15);
    push_exp(32'h1100, 8'd7);
    hs0 = hs_cnt;
    send_cmd(32'h1000, 16'd40);
    @(negedge clk);
    chk("t1_busy", 64'(busy), 64'(1));
    wait_done(500, at);
    chk("t1_done_latency", 64'(at - last_down_cyc), 64'(1));
    chk("t1_hs_count", 64'(hs_cnt - hs0), 64'(3));
    @(negedge clk);
    chk("t1_idle_after", 64'(busy), 64'(0));
    chk("t1_done_one_cycle", 64'(done), 64'(0));

    // 2: empty transfer
    rv0 = rv_cnt;
    send_cmd(32'h2000, 16'd0);
    @(negedge clk);
    chk("t2_done", 64'(done), 64'(1));
    chk("t2_busy", 64'(busy), 64'(0));
    @(negedge clk);
    chk("t2_done_pulse", 64'(done), 64'(0));
    chk("t2_no_req", 64'(rv_cnt - rv0), 64'(0));

    // 3: no responses, tracker fills at 4
    auto_rsp = 1'b0;
    for (int unsigned i = 0; i < 10; i++) push_exp(32'h4000 + i * 128, 8'd15);
    hs0 = hs_cnt;
    send_cmd(32'h4000, 16'd160);
    repeat (20) @(negedge clk);
    chk("t3_full_hs", 64'(hs_cnt - hs0), 64'(4));
    chk("t3_stalled", 64'(bus.req_valid), 64'(0));
    inject = 1'b1;
    repeat (4) @(negedge clk);
    chk("t3_fifth_hs", 64'(hs_cnt - hs0), 64'(5));
    auto_rsp = 1'b1;
    for (int unsigned i = 0; i < 4; i++) rsp_q.push_back(1);
    wait_done(2000, at);
    chk("t3_total_hs", 64'(hs_cnt - hs0), 64'(10));
    chk("t3_sb_empty", 64'(exp_q.size()), 64'(0));

    // 4: 4 KB boundary
`ifdef BURST_BOUNDARY_4K_EN
    push_exp(32'h0FC0, 8'd7);
    push_exp(32'h1000, 8'd7);
`else
    push_exp(32'h0FC0, 8'd15);
`endif
    send_cmd(32'h0FC7, 16'd16);
    wait_done(500, at);
    chk("t4_sb_empty", 64'(exp_q.size()), 64'(0));
    chk("t4_no_err", 64'(err_rsp), 64'(0));

    // 5: reset with a request pending
    @(posedge clk);
    #1;
    bus.req_ready = 1'b0;
    send_cmd(32'h8000, 16'd32);
    repeat (3) @(negedge clk);
    chk("t5_pending", 64'(bus.req_valid), 64'(1));
    bus.req_ready = 1'b1;
    rst = 1'b1;
    #1;
    chk("t5_rst_req_valid", 64'(bus.req_valid), 64'(0));
    chk("t5_rst_busy", 64'(busy), 64'(0));
    chk("t5_rst_trk_up", 64'(bus.trk_up), 64'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    push_exp(32'h9000, 8'd15);
    push_exp(32'h9080, 8'd3);
    send_cmd(32'h9000, 16'd20);
    wait_done(500, at);
    chk("t5_sb_empty", 64'(exp_q.size()), 64'(0));

    // 6: stray rsp_last while idle
    repeat (3) @(negedge clk);
    inject = 1'b1;
    @(negedge clk);
    chk("t6_rsp_seen", 64'(bus.rsp_last), 64'(1));
    chk("t6_trk_down", 64'(bus.trk_down), 64'(0));
    @(negedge clk);
    chk("t6_err_set", 64'(err_rsp), 64'(1));
    repeat (5) @(negedge clk);
    chk("t6_err_sticky", 64'(err_rsp), 64'(1));
    rst = 1'b1;
    #1;
    chk("t6_err_cleared", 64'(err_rsp), 64'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (2) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
